// File: rtl/sfx_pkg.sv
// Shared types and tables for the sound effect block: effect IDs, note
// half-periods and the per-effect step sequence ROM.
package sfx_pkg;

  localparam int NOTE_W = 3;
  localparam int DUR_W  = 5;
  localparam int STEP_W = 2;
  localparam int DIV_W  = 16;

  // Enum order doubles as priority: a larger value wins.
  typedef enum logic [2:0] {
    NONE    = 3'd0,
    TICK    = 3'd1,
    EAT     = 3'd2,
    SUCCESS = 3'd3,
    FAILURE = 3'd4
  } fx_e;

  typedef struct packed {
    logic [NOTE_W-1:0] note;
    logic [DUR_W-1:0]  dur;
  } step_t;

  function automatic logic [DIV_W-1:0] note_half(input logic [NOTE_W-1:0] n);
    logic [DIV_W-1:0] hp;
    case (n)
      3'd1:    hp = 16'd48000;
      3'd2:    hp = 16'd38000;
      3'd3:    hp = 16'd32000;
      3'd4:    hp = 16'd24000;
      3'd5:    hp = 16'd19000;
      3'd6:    hp = 16'd16000;
      3'd7:    hp = 16'd12000;
      default: hp = '0;
    endcase
    return hp;
  endfunction

  function automatic step_t seq_rom(input fx_e fx, input logic [STEP_W-1:0] s);
    step_t r;
    r = '0;
    case (fx)
      TICK: r = {3'd7, 5'd1};
      EAT:
        case (s)
          2'd0:    r = {3'd5, 5'd3};
          default: r = {3'd7, 5'd3};
        endcase
      SUCCESS:
        case (s)
          2'd0:    r = {3'd3, 5'd6};
          2'd1:    r = {3'd4, 5'd6};
          2'd2:    r = {3'd5, 5'd6};
          default: r = {3'd7, 5'd12};
        endcase
      FAILURE:
        case (s)
          2'd0:    r = {3'd4, 5'd8};
          2'd1:    r = {3'd3, 5'd8};
          2'd2:    r = {3'd2, 5'd8};
          default: r = {3'd1, 5'd16};
        endcase
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [STEP_W-1:0] last_step(input fx_e fx);
    logic [STEP_W-1:0] l;
    case (fx)
      EAT:              l = 2'd1;
      SUCCESS, FAILURE: l = 2'd3;
      default:          l = 2'd0;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/tone_gen.sv
// Square-wave generator: counts clk cycles and toggles the output every
// half_period cycles. A zero half-period is a rest and holds the wave low.
module tone_gen
  import sfx_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [DIV_W-1:0] half_period,
  output logic             wave
);

  logic [DIV_W-1:0] div_q, div_d;
  logic             wave_q, wave_d;

  always_comb begin
    div_d  = div_q + 1'b1;
    wave_d = wave_q;
    if (clear || half_period == '0) begin
      div_d  = '0;
      wave_d = 1'b0;
    end else if (div_q == half_period - 1'b1) begin
      div_d  = '0;
      wave_d = ~wave_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q  <= '0;
      wave_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      wave_q <= wave_d;
    end
  end

  assign wave = wave_q;

endmodule

// File: rtl/sound_fx.sv
// Game sound effect sequencer, driven by the game top's tick/eat/success/
// failure flags and VGA vsync; plays prioritized note sequences timed in frames.
module sound_fx
  import sfx_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_vsync,
  input  logic i_tick,
  input  logic i_eat,
  input  logic i_success,
  input  logic i_failure,
  input  logic i_mute,
  output logic o_audio,
  output logic o_busy
);

  typedef enum logic {IDLE, PLAY} state_e;

  state_e            state_q;
  fx_e               fx_q, req;
  logic [STEP_W-1:0] step_q;
  logic [DUR_W-1:0]  fcnt_q;
  logic              vsync_q, tick_q, eat_q, succ_q, fail_q;
  logic              vs_rise, accept, step_done, tg_clear, wave;
  step_t             cur;

  always_comb begin
    vs_rise = i_vsync & ~vsync_q;
    req     = NONE;
    if      (i_failure & ~fail_q) req = FAILURE;
    else if (i_success & ~succ_q) req = SUCCESS;
    else if (i_eat & ~eat_q)      req = EAT;
    else if (i_tick & ~tick_q)    req = TICK;
    // Equal priority restarts; lower priority is dropped outright.
    accept    = (req != NONE) && (state_q == IDLE || req >= fx_q);
    cur       = seq_rom(fx_q, step_q);
    step_done = (state_q == PLAY) && !accept && vs_rise && (fcnt_q + 1'b1 == cur.dur);
    tg_clear  = (state_q != PLAY) || accept || step_done;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      fx_q    <= NONE;
      step_q  <= '0;
      fcnt_q  <= '0;
      vsync_q <= 1'b0;
      tick_q  <= 1'b0;
      eat_q   <= 1'b0;
      succ_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      vsync_q <= i_vsync;
      tick_q  <= i_tick;
      eat_q   <= i_eat;
      succ_q  <= i_success;
      fail_q  <= i_failure;
      if (accept) begin
        state_q <= PLAY;
        fx_q    <= req;
        step_q  <= '0;
        fcnt_q  <= '0;
      end else if (state_q == PLAY && vs_rise) begin
        if (step_done) begin
          fcnt_q <= '0;
          if (step_q == last_step(fx_q)) begin
            state_q <= IDLE;
            fx_q    <= NONE;
            step_q  <= '0;
          end else begin
            step_q <= step_q + 1'b1;
          end
        end else begin
          fcnt_q <= fcnt_q + 1'b1;
        end
      end
    end
  end

  tone_gen u_tone (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (tg_clear),
    .half_period(note_half(cur.note)),
    .wave       (wave)
  );

  assign o_busy  = (state_q == PLAY);
  assign o_audio = wave & ~i_mute;

endmodule

// File: tb/tb_sound_fx.sv
// Scoreboard bench: stimulus queues the expected {busy,audio} change events,
// the monitor pops one each time the outputs change and checks cycle and value.
module tb_sound_fx;

  logic clk = 1'b0, rst_n = 1'b0;
  logic i_vsync = 1'b0, i_tick = 1'b0, i_eat = 1'b0;
  logic i_success = 1'b0, i_failure = 1'b0, i_mute = 1'b0;
  logic o_audio, o_busy;

  sound_fx dut (
    .clk(clk), .rst_n(rst_n), .i_vsync(i_vsync), .i_tick(i_tick), .i_eat(i_eat),
    .i_success(i_success), .i_failure(i_failure), .i_mute(i_mute),
    .o_audio(o_audio), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int c; logic b; logic a; } ev_t;
  ev_t q[$];
  int  n_vec = 0, n_err = 0;
  bit  mon_en = 1'b0;
  logic [1:0] prev = 2'b00;

  task automatic ex(input int c, input logic b, input logic a);
    ev_t e;
    e.c = c; e.b = b; e.a = a;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (mon_en && ({o_busy, o_audio} !== prev)) begin
      n_vec++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_change cyc=%0d got busy=%b audio=%b, none expected", cyc, o_busy, o_audio);
      end else begin
        e = q.pop_front();
        if (e.c != cyc || e.b !== o_busy || e.a !== o_audio) begin
          n_err++;
          $display("FAIL event got cyc=%0d busy=%b audio=%b, want cyc=%0d busy=%b audio=%b",
                   cyc, o_busy, o_audio, e.c, e.b, e.a);
        end
      end
      prev = {o_busy, o_audio};
    end
  end

  task automatic step1();
    @(posedge clk); #1;
  endtask

  task automatic goto_c(input int t);
    while (cyc < t) step1();
  endtask

  task automatic vs_pulse(input int t);
    goto_c(t);
    i_vsync = 1'b1;
    step1();
    i_vsync = 1'b0;
  endtask

  initial begin
    int n, base, r;
    ev_t e;
    repeat (3) step1();
    n_vec++;
    if (o_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", o_busy); end
    n_vec++;
    if (o_audio !== 1'b0) begin n_err++; $display("FAIL reset_audio got %b want 0", o_audio); end
    rst_n = 1'b1;
    step1();
    mon_en = 1'b1;
    repeat (5) step1();

    // TICK: busy next cycle, done after one frame
    n = cyc;
    i_tick = 1'b1;
    ex(n + 1, 1, 0); ex(n + 1001, 0, 0);
    step1(); i_tick = 1'b0;
    vs_pulse(n + 1000);
    goto_c(n + 1100);

    // EAT: note 5 rises after 19000, cleared at step boundary, then note 7
    n = cyc;
    i_eat = 1'b1;
    ex(n + 1, 1, 0); ex(n + 19001, 1, 1); ex(n + 19501, 1, 0); ex(n + 22501, 0, 0);
    step1(); i_eat = 1'b0;
    vs_pulse(n + 1000); vs_pulse(n + 2000); vs_pulse(n + 19500);
    vs_pulse(n + 20500); vs_pulse(n + 21500); vs_pulse(n + 22500);
    goto_c(n + 22600);

    // TICK+FAILURE together: FAILURE wins; EAT during step 2 ignored; 40 frames
    n = cyc;
    i_tick = 1'b1; i_failure = 1'b1;
    ex(n + 1, 1, 0); ex(n + 24001, 1, 1); ex(n + 24501, 1, 0); ex(n + 27701, 0, 0);
    step1(); i_tick = 1'b0; i_failure = 1'b0;
    for (int k = 1; k <= 7; k++) vs_pulse(n + 100 * k);
    vs_pulse(n + 24500);
    base = n + 24500;
    for (int k = 1; k <= 32; k++) begin
      if (k == 13) begin
        goto_c(base + 1250);
        i_eat = 1'b1; step1(); i_eat = 1'b0;
      end
      vs_pulse(base + 100 * k);
    end
    goto_c(base + 3300);

    // EAT re-edge in step 1 restarts from step 0; lower-priority TICK dropped
    n = cyc;
    i_eat = 1'b1;
    ex(n + 1, 1, 0); ex(n + 1001, 0, 0);
    step1(); i_eat = 1'b0;
    for (int k = 1; k <= 4; k++) vs_pulse(n + 100 * k);
    goto_c(n + 450);
    i_eat = 1'b1; step1(); i_eat = 1'b0;
    vs_pulse(n + 500); vs_pulse(n + 600);
    goto_c(n + 650);
    i_tick = 1'b1; step1(); i_tick = 1'b0;
    for (int k = 7; k <= 10; k++) vs_pulse(n + 100 * k);
    goto_c(n + 1100);

    // Muted SUCCESS: audio silent, busy spans exactly 30 frames
    i_mute = 1'b1;
    step1();
    n = cyc;
    i_success = 1'b1;
    ex(n + 1, 1, 0); ex(n + 3001, 0, 0);
    step1(); i_success = 1'b0;
    for (int k = 1; k <= 30; k++) vs_pulse(n + 100 * k);
    goto_c(n + 3100);
    i_mute = 1'b0;
    step1();

    // TICK held: 12000-cycle toggle, live mute, reset abort, edge after reset
    n = cyc;
    r = n + 12200;
    i_tick = 1'b1;
    ex(n + 1, 1, 0); ex(n + 12001, 1, 1); ex(n + 12100, 1, 0); ex(n + 12150, 1, 1);
    ex(r + 1, 0, 0); ex(r + 2, 1, 0); ex(r + 601, 0, 0);
    goto_c(n + 12100); i_mute = 1'b1;
    goto_c(n + 12150); i_mute = 1'b0;
    goto_c(r); rst_n = 1'b0;
    step1(); rst_n = 1'b1;
    goto_c(r + 10); i_tick = 1'b0;
    vs_pulse(r + 600);
    goto_c(r + 700);

    while (q.size() != 0) begin
      e = q.pop_front();
      n_vec++; n_err++;
      $display("FAIL missing_event got none, want cyc=%0d busy=%b audio=%b", e.c, e.b, e.a);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
